// File: rtl/gifplayer_soc_led_pio.sv
// Avalon-MM LED/output port: DATA with atomic set/clear/toggle, per-bit blink, optional PWM dimming (LED_PIO_PWM_EN).
// Latency: readdata one cycle after the read strobe; out_port one cycle after the register change.
// Backpressure: none, every access completes in a single cycle (no waitrequest).
module gifplayer_soc_led_pio #(
    parameter int               WIDTH       = 8,
    parameter int               PRESC_W     = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic [2:0]       address,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic               wr;
    logic               rd;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   blink_mask_q;
    logic [PRESC_W-1:0] prescale_q;
    logic [PRESC_W-1:0] cnt_q;
    logic               phase_q;
    logic [31:0]        rd_mux;
    logic [WIDTH-1:0]   pwm_gate;
    logic               unused_wd;

    assign wr        = chipselect & ~write_n;
    assign rd        = chipselect & ~read_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

`ifdef LED_PIO_PWM_EN
    logic [7:0] dim_q;
    logic [7:0] pwm_cnt_q;

    assign pwm_gate = {WIDTH{(pwm_cnt_q < dim_q) || (dim_q == 8'hFF)}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dim_q     <= 8'hFF;
            pwm_cnt_q <= 8'h00;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (wr && address == 3'd7)
                dim_q <= writedata[7:0];
        end
    end
`else
    assign pwm_gate = '1;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux[WIDTH-1:0]   = data_q;
            3'd1: rd_mux[WIDTH-1:0]   = blink_mask_q;
            3'd2: rd_mux[PRESC_W-1:0] = prescale_q;
            3'd3: rd_mux[1:0]         = {(blink_mask_q != '0), phase_q};
`ifdef LED_PIO_PWM_EN
            3'd7: rd_mux[7:0]         = dim_q;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= RESET_VALUE;
            blink_mask_q <= '0;
        end else if (wr) begin
            case (address)
                3'd0:    data_q       <= wd;
                3'd1:    blink_mask_q <= wd;
                3'd4:    data_q       <= data_q | wd;
                3'd5:    data_q       <= data_q & ~wd;
                3'd6:    data_q       <= data_q ^ wd;
                default: ;
            endcase
        end
    end

    // A PRESCALE write restarts the half-period, overriding a coincident wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= '1;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
        end else if (wr && address == 3'd2) begin
            prescale_q <= writedata[PRESC_W-1:0];
            cnt_q      <= '0;
            phase_q    <= 1'b0;
        end else if (cnt_q == prescale_q) begin
            cnt_q      <= '0;
            phase_q    <= ~phase_q;
        end else begin
            cnt_q      <= cnt_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            out_port <= RESET_VALUE;
        end else begin
            if (rd)
                readdata <= rd_mux;
            out_port <= data_q & ~(blink_mask_q & {WIDTH{phase_q}}) & pwm_gate;
        end
    end

endmodule

// File: tb/tb_gifplayer_soc_led_pio.sv
// Bench for gifplayer_soc_led_pio: vector table, corner-case sequences and random traffic against a time-based model.
module tb_gifplayer_soc_led_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    always #5 clk = ~clk;

    gifplayer_soc_led_pio #(
        .WIDTH(8), .PRESC_W(24), .RESET_VALUE(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .readdata(readdata), .out_port(out_port)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: blink phase derived from elapsed edges since the last restart.
    logic [7:0]  m_data, m_mask, m_dim, m_out;
    logic [23:0] m_presc;
    logic [31:0] m_rd;
    longint      m_pstart, edges;

    task automatic model_reset();
        m_data = 8'hA5; m_mask = 8'h00; m_dim = 8'hFF; m_presc = 24'hFFFFFF;
        m_pstart = 0; edges = 0; m_rd = 32'h0; m_out = 8'hA5;
    endtask

    function automatic logic m_phase();
        longint n;
        n = edges - m_pstart;
        return ((n / (longint'(m_presc) + 1)) % 2) == 1;
    endfunction

    function automatic logic [31:0] reg_val(input logic [2:0] a, input logic ph);
        case (a)
            3'd0: return {24'h0, m_data};
            3'd1: return {24'h0, m_mask};
            3'd2: return {8'h0, m_presc};
            3'd3: return {30'h0, (m_mask != 8'h00), ph};
`ifdef LED_PIO_PWM_EN
            3'd7: return {24'h0, m_dim};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic cyc(input logic cs, input logic [2:0] a, input logic wn, input logic rn,
                       input logic [31:0] wd);
        logic ph;
        logic gate;
        chipselect = cs; address = a; write_n = wn; read_n = rn; writedata = wd;
        ph = m_phase();
`ifdef LED_PIO_PWM_EN
        gate = ((edges % 256) < longint'(m_dim)) || (m_dim == 8'hFF);
`else
        gate = 1'b1;
`endif
        m_out = m_data & ~(m_mask & {8{ph}}) & {8{gate}};
        if (cs && !rn)
            m_rd = reg_val(a, ph);
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: m_mask = wd[7:0];
                3'd2: begin m_presc = wd[23:0]; m_pstart = edges + 1; end
                3'd4: m_data = m_data | wd[7:0];
                3'd5: m_data = m_data & ~wd[7:0];
                3'd6: m_data = m_data ^ wd[7:0];
`ifdef LED_PIO_PWM_EN
                3'd7: m_dim = wd[7:0];
`endif
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        edges++;
        check("model_out_port", {24'h0, out_port}, {24'h0, m_out});
        check("model_readdata", readdata, m_rd);
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, a, 1'b0, 1'b1, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        cyc(1'b1, a, 1'b1, 1'b0, 32'h0);
    endtask

    typedef struct {
        logic [2:0]  a;
        logic        is_wr;
        logic [31:0] wd;
        logic        rd_chk;
        logic [31:0] exp_rd;
        logic        o_chk;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t tbl[14];
    int   cnt_hi;

    initial begin
        tbl[0]  = '{3'd0, 1'b0, 32'h0,        1'b1, 32'h000000A5, 1'b1, 8'hA5};
        tbl[1]  = '{3'd1, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b0, 8'h00};
        tbl[2]  = '{3'd3, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b0, 8'h00};
        tbl[3]  = '{3'd0, 1'b1, 32'h0000000F, 1'b0, 32'h0,        1'b0, 8'h00};
        tbl[4]  = '{3'd4, 1'b1, 32'h000000F0, 1'b0, 32'h0,        1'b0, 8'h00};
        tbl[5]  = '{3'd5, 1'b1, 32'h00000003, 1'b0, 32'h0,        1'b0, 8'h00};
        tbl[6]  = '{3'd6, 1'b1, 32'h00000081, 1'b0, 32'h0,        1'b0, 8'h00};
        tbl[7]  = '{3'd0, 1'b0, 32'h0,        1'b1, 32'h0000007D, 1'b1, 8'h7D};
        tbl[8]  = '{3'd4, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 8'h7D};
        tbl[9]  = '{3'd3, 1'b1, 32'h000000FF, 1'b0, 32'h0,        1'b0, 8'h00};
        tbl[10] = '{3'd3, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b0, 8'h00};
        tbl[11] = '{3'd0, 1'b1, 32'hFFFFFF12, 1'b0, 32'h0,        1'b0, 8'h00};
        tbl[12] = '{3'd0, 1'b0, 32'h0,        1'b1, 32'h00000012, 1'b1, 8'h12};
        tbl[13] = '{3'd2, 1'b0, 32'h0,        1'b1, 32'h00FFFFFF, 1'b0, 8'h00};

        reset = 1'b1; chipselect = 1'b0; address = 3'd0;
        write_n = 1'b1; read_n = 1'b1; writedata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_port", {24'h0, out_port}, 32'hA5);
        check("reset_readdata", readdata, 32'h0);
        reset = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            if (tbl[i].is_wr) wr_reg(tbl[i].a, tbl[i].wd);
            else              rd_reg(tbl[i].a);
            if (tbl[i].rd_chk) check("vec_readdata", readdata, tbl[i].exp_rd);
            if (tbl[i].o_chk)  check("vec_out_port", {24'h0, out_port}, {24'h0, tbl[i].exp_out});
        end

        // Blink: 4 clocks high, 4 clocks low on bit 0
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd2, 32'h3);
        for (int i = 0; i < 16; i++) begin
            idle();
            check("blink_bit0", {31'h0, out_port[0]}, {31'h0, ((i / 4) % 2) == 0});
            check("blink_upper", {25'h0, out_port[7:1]}, 32'h7F);
        end

        // PRESCALE write landing on the wrap edge
        wr_reg(3'd2, 32'h3);
        repeat (3) idle();
        wr_reg(3'd2, 32'h3);
        rd_reg(3'd3);
        check("wrap_write_status", readdata, 32'h2);
        repeat (3) idle();
        rd_reg(3'd3);
        check("after_wrap_status", readdata, 32'h3);

        // Concurrent read and write return the old value
        wr_reg(3'd1, 32'h0);
        wr_reg(3'd0, 32'hAA);
        cyc(1'b1, 3'd0, 1'b0, 1'b0, 32'h55);
        check("rw_same_cycle", readdata, 32'hAA);
        rd_reg(3'd0);
        check("rw_after", readdata, 32'h55);

        wr_reg(3'd7, 32'h40);
        rd_reg(3'd7);
`ifdef LED_PIO_PWM_EN
        check("dim_readback", readdata, 32'h40);
        wr_reg(3'd0, 32'hFF);
        idle();
        cnt_hi = 0;
        for (int i = 0; i < 256; i++) begin
            idle();
            if (out_port == 8'hFF) cnt_hi++;
        end
        check("pwm_dim64_high", cnt_hi, 64);
        wr_reg(3'd7, 32'h0);
        idle();
        cnt_hi = 0;
        for (int i = 0; i < 256; i++) begin
            idle();
            if (out_port != 8'h00) cnt_hi++;
        end
        check("pwm_dim0_high", cnt_hi, 0);
        wr_reg(3'd7, 32'hFF);
`else
        check("addr7_reads_zero", readdata, 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
            cyc($urandom_range(0, 3) != 0, a, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), d);
        end

        // Asynchronous reset in the middle of traffic
        wr_reg(3'd0, 32'h3C);
        rd_reg(3'd0);
        reset = 1'b1;
        #2;
        check("midreset_out_port", {24'h0, out_port}, 32'hA5);
        check("midreset_readdata", readdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle();
        rd_reg(3'd0);
        check("postreset_data", readdata, 32'hA5);
        rd_reg(3'd1);
        check("postreset_mask", readdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
